scarv_cop_issue: RTL and testbench
==================================

SCARV_COP_ISSUE -- requirements
Module: scarv_cop_issue

Interface
REQ-001 Parameter TIMEOUT, default 255: cycles allowed in REQ plus WAIT before the block aborts the instruction.
REQ-002 Ports (name, direction, width, meaning):
- g_clk  in  1  single clock, rising edge.
- g_reset  in  1  asynchronous, active-high reset.
- pl_valid  in  1  pipeline presents an instruction.
- pl_ready  out  1  block accepts an instruction.
- pl_insn  in  32  encoded instruction.
- pl_rs1  in  32  GPR rs1 operand.
- pl_flush  in  1  kill the in-flight instruction.
- cop_req  out  1  request to coprocessor.
- cop_ack  in  1  coprocessor accepted the request.
- cop_insn  out  32  registered instruction.
- cop_rs1  out  32  registered operand.
- cop_rsp  in  1  coprocessor response valid.
- cop_rsp_ack  out  1  response consumed.
- cop_result  in  3  coprocessor status, 0 means success.
- cop_wen  in  1  GPR write requested.
- cop_waddr  in  5  GPR write address.
- cop_wdata  in  32  GPR write data.
- wb_valid  out  1  writeback record valid.
- wb_ready  in  1  pipeline consumes the record.
- wb_code  out  3  status code.
- wb_wen  out  1  GPR write enable.
- wb_waddr  out  5  GPR write address.
- wb_wdata  out  32  GPR write data.

Function
REQ-003 FSM states: IDLE, REQ, WAIT, WB; one instruction in flight; single-bit outputs derive from state or capture registers.
REQ-004 IDLE: pl_ready=1; all other handshake outputs 0.
REQ-005 Acceptance (IDLE with pl_valid=1):
- Capture pl_insn and pl_rs1.
- Clear the timeout counter.
- If pl_insn[6:0] is not custom-0, custom-1 or custom-2 (0001011, 0101011, 1011011): go to WB with wb_code=110 (ILLEGAL) and wb_wen=0; the coprocessor is never contacted.
- Otherwise go to REQ.
REQ-006 REQ: cop_req=1; cop_insn and cop_rs1 hold the captured values and stay stable until cop_ack.
REQ-007 REQ with cop_ack=1: go to WAIT. If cop_rsp=1 in the same cycle, the response is captured immediately and the block goes to WB.
REQ-008 WAIT: cop_rsp_ack=1. On cop_rsp=1:
- Capture cop_result into wb_code.
- Capture wb_wen = cop_wen AND (cop_result==0); capture cop_waddr and cop_wdata.
- Go to WB.
REQ-009 Timeout counter:
- Increments each cycle in REQ or WAIT; saturates.
- On reaching TIMEOUT: drop cop_req, go to WB with wb_code=111 (TIMEOUT) and wb_wen=0.
- A response arriving in the same cycle as the timeout takes priority.
REQ-010 WB: wb_valid=1 with all wb_* fields stable until wb_ready; on wb_ready go to IDLE. pl_ready stays 0 in WB (no same-cycle re-accept).
REQ-011 Flush:
- pl_flush in REQ: go to IDLE; cop_req drops next cycle.
- pl_flush in WAIT: set a discard flag. The block still waits for cop_rsp (or timeout), then goes to IDLE without asserting wb_valid.
- pl_flush in WB: go to IDLE.
- pl_flush in IDLE: no effect; it blocks acceptance that cycle.
REQ-012 Latency: instruction accepted at cycle T gives cop_req at T+1. With ack at T+1 and response at T+2, wb_valid asserts at T+3. An illegal instruction gives wb_valid at T+1.
REQ-013 Non-zero COP codes 001..111 pass through unchanged; 000 means success.

Reset
REQ-014 g_reset asynchronously forces IDLE, clears the counter and discard flag, and zeroes all outputs except pl_ready, which is 1 after reset.
REQ-015 Reset mid-transaction abandons the instruction; no wb_valid is produced for it.

Structure
REQ-016 A shared package holds:
- FSM state encoding.
- wb_code constants: OK=000, ILLEGAL=110, TIMEOUT=111.
- Custom opcode constants.
REQ-017 Flat implementation; no sub-modules.

Verification
REQ-018 Normal: insn 0x0000000B, rs1 0x1234; ack at +1, rsp at +2 with result=0, wen=1, waddr=5, wdata=0xCAFEF00D -> wb_valid at T+3 with those values and code 000.
REQ-019 Illegal: insn 0x00000033 -> wb_valid at T+1, code 110, wen=0; cop_req never asserts.
REQ-020 Backpressure: cop_ack held 0 for 10 cycles -> cop_req, cop_insn and cop_rs1 stable throughout; wb_ready held 0 for 5 cycles -> wb fields stable.
REQ-021 Timeout: TIMEOUT=8, no ack -> wb code 111 after 8 cycles in REQ; cop_req drops.
REQ-022 Flush in WAIT, then rsp with result=0 and wen=1 -> no wb_valid; pl_ready returns to 1.
REQ-023 Reset asserted in WAIT -> outputs zero immediately except pl_ready=1; no wb record follows.

Source files
------------

// File: rtl/scarv_cop_issue_pkg.sv
// Shared types and constants for the coprocessor issue block: FSM encoding,
// writeback status codes and the custom opcodes routed to the coprocessor.
package scarv_cop_issue_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StWb   = 2'd3
  } issue_state_e;

  localparam logic [2:0] WbCodeOk      = 3'b000;
  localparam logic [2:0] WbCodeIllegal = 3'b110;
  localparam logic [2:0] WbCodeTimeout = 3'b111;

  localparam logic [6:0] OpCustom0 = 7'b0001011;
  localparam logic [6:0] OpCustom1 = 7'b0101011;
  localparam logic [6:0] OpCustom2 = 7'b1011011;

  function automatic logic is_cop_opcode(input logic [6:0] opcode);
    return (opcode == OpCustom0) || (opcode == OpCustom1) || (opcode == OpCustom2);
  endfunction

endpackage

// File: rtl/scarv_cop_issue.sv
// Issues one custom instruction at a time to a coprocessor, waits for its
// response (with timeout and flush handling) and presents a writeback record.
module scarv_cop_issue
  import scarv_cop_issue_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        pl_valid,
  output logic        pl_ready,
  input  logic [31:0] pl_insn,
  input  logic [31:0] pl_rs1,
  input  logic        pl_flush,
  output logic        cop_req,
  input  logic        cop_ack,
  output logic [31:0] cop_insn,
  output logic [31:0] cop_rs1,
  input  logic        cop_rsp,
  output logic        cop_rsp_ack,
  input  logic [2:0]  cop_result,
  input  logic        cop_wen,
  input  logic [4:0]  cop_waddr,
  input  logic [31:0] cop_wdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [2:0]  wb_code,
  output logic        wb_wen,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  issue_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            discard_q, discard_d;
  logic [31:0]     insn_q, insn_d;
  logic [31:0]     rs1_q, rs1_d;
  logic [2:0]      code_q, code_d;
  logic            wen_q, wen_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;

  logic [CntW-1:0] cnt_inc;
  logic            timeout_hit;
  logic            discard_next;

  // Counter value after the current REQ/WAIT cycle; saturates at TIMEOUT.
  assign cnt_inc     = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
  assign timeout_hit = (cnt_inc == CntMax);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    discard_d    = discard_q;
    insn_d       = insn_q;
    rs1_d        = rs1_q;
    code_d       = code_q;
    wen_d        = wen_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    discard_next = discard_q | pl_flush;

    unique case (state_q)
      StIdle: begin
        if (pl_valid && !pl_flush) begin
          insn_d    = pl_insn;
          rs1_d     = pl_rs1;
          cnt_d     = '0;
          discard_d = 1'b0;
          if (is_cop_opcode(pl_insn[6:0])) begin
            state_d = StReq;
          end else begin
            code_d  = WbCodeIllegal;
            wen_d   = 1'b0;
            waddr_d = '0;
            wdata_d = '0;
            state_d = StWb;
          end
        end
      end

      StReq: begin
        cnt_d = cnt_inc;
        if (pl_flush) begin
          state_d = StIdle;
        end else if (cop_ack && cop_rsp) begin
          code_d  = cop_result;
          wen_d   = cop_wen && (cop_result == WbCodeOk);
          waddr_d = cop_waddr;
          wdata_d = cop_wdata;
          state_d = StWb;
        end else if (timeout_hit) begin
          code_d  = WbCodeTimeout;
          wen_d   = 1'b0;
          waddr_d = '0;
          wdata_d = '0;
          state_d = StWb;
        end else if (cop_ack) begin
          state_d = StWait;
        end
      end

      StWait: begin
        cnt_d     = cnt_inc;
        discard_d = discard_next;
        // A flushed instruction still drains its response, then vanishes.
        if (cop_rsp) begin
          if (discard_next) begin
            state_d = StIdle;
          end else begin
            code_d  = cop_result;
            wen_d   = cop_wen && (cop_result == WbCodeOk);
            waddr_d = cop_waddr;
            wdata_d = cop_wdata;
            state_d = StWb;
          end
        end else if (timeout_hit) begin
          if (discard_next) begin
            state_d = StIdle;
          end else begin
            code_d  = WbCodeTimeout;
            wen_d   = 1'b0;
            waddr_d = '0;
            wdata_d = '0;
            state_d = StWb;
          end
        end
      end

      StWb: begin
        if (pl_flush || wb_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      discard_q <= 1'b0;
      insn_q    <= '0;
      rs1_q     <= '0;
      code_q    <= '0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      discard_q <= discard_d;
      insn_q    <= insn_d;
      rs1_q     <= rs1_d;
      code_q    <= code_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign pl_ready    = (state_q == StIdle);
  assign cop_req     = (state_q == StReq);
  assign cop_rsp_ack = (state_q == StWait);
  assign wb_valid    = (state_q == StWb);
  assign cop_insn    = insn_q;
  assign cop_rs1     = rs1_q;
  assign wb_code     = code_q;
  assign wb_wen      = wen_q;
  assign wb_waddr    = waddr_q;
  assign wb_wdata    = wdata_q;

endmodule

// File: tb/tb_scarv_cop_issue.sv
// Directed bench for scarv_cop_issue; a second instance with TIMEOUT=8
// shares the stimulus and is used for the timeout scenario.
module tb_scarv_cop_issue;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        pl_valid = 1'b0;
  logic [31:0] pl_insn = '0;
  logic [31:0] pl_rs1 = '0;
  logic        pl_flush = 1'b0;
  logic        cop_ack = 1'b0;
  logic        cop_rsp = 1'b0;
  logic [2:0]  cop_result = '0;
  logic        cop_wen = 1'b0;
  logic [4:0]  cop_waddr = '0;
  logic [31:0] cop_wdata = '0;
  logic        wb_ready = 1'b0;

  logic        pl_ready, cop_req, cop_rsp_ack, wb_valid, wb_wen;
  logic [31:0] cop_insn, cop_rs1, wb_wdata;
  logic [2:0]  wb_code;
  logic [4:0]  wb_waddr;

  logic        t_pl_ready, t_cop_req, t_cop_rsp_ack, t_wb_valid, t_wb_wen;
  logic [31:0] t_cop_insn, t_cop_rs1, t_wb_wdata;
  logic [2:0]  t_wb_code;
  logic [4:0]  t_wb_waddr;

  int vectors = 0;
  int miscompares = 0;

  always #5 g_clk = ~g_clk;

  scarv_cop_issue u_dut (
    .g_clk(g_clk), .g_reset(g_reset), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .pl_insn(pl_insn), .pl_rs1(pl_rs1), .pl_flush(pl_flush), .cop_req(cop_req),
    .cop_ack(cop_ack), .cop_insn(cop_insn), .cop_rs1(cop_rs1), .cop_rsp(cop_rsp),
    .cop_rsp_ack(cop_rsp_ack), .cop_result(cop_result), .cop_wen(cop_wen),
    .cop_waddr(cop_waddr), .cop_wdata(cop_wdata), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_code(wb_code), .wb_wen(wb_wen), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata)
  );

  scarv_cop_issue #(.TIMEOUT(8)) u_dut_to (
    .g_clk(g_clk), .g_reset(g_reset), .pl_valid(pl_valid), .pl_ready(t_pl_ready),
    .pl_insn(pl_insn), .pl_rs1(pl_rs1), .pl_flush(pl_flush), .cop_req(t_cop_req),
    .cop_ack(cop_ack), .cop_insn(t_cop_insn), .cop_rs1(t_cop_rs1), .cop_rsp(cop_rsp),
    .cop_rsp_ack(t_cop_rsp_ack), .cop_result(cop_result), .cop_wen(cop_wen),
    .cop_waddr(cop_waddr), .cop_wdata(cop_wdata), .wb_valid(t_wb_valid),
    .wb_ready(wb_ready), .wb_code(t_wb_code), .wb_wen(t_wb_wen), .wb_waddr(t_wb_waddr),
    .wb_wdata(t_wb_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge.
  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic do_reset();
    g_reset = 1'b1;
    step();
    g_reset = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_pl_ready", pl_ready, 1);
    chk("rst_cop_req", cop_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_cop_insn", cop_insn, 0);
    chk("rst_wb_wdata", wb_wdata, 0);
    step();
    g_reset = 1'b0;

    // Flush in IDLE blocks acceptance
    pl_valid = 1'b1; pl_insn = 32'h0000000B; pl_flush = 1'b1;
    step();
    chk("idle_flush_req", cop_req, 0);
    chk("idle_flush_rdy", pl_ready, 1);
    pl_flush = 1'b0;

    // Normal transaction: accept at T, ack T+1, rsp T+2, wb at T+3
    pl_insn = 32'h0000000B; pl_rs1 = 32'h00001234;
    step();
    pl_valid = 1'b0;
    chk("norm_req", cop_req, 1);
    chk("norm_insn", cop_insn, 32'h0000000B);
    chk("norm_rs1", cop_rs1, 32'h00001234);
    chk("norm_rdy_busy", pl_ready, 0);
    cop_ack = 1'b1;
    step();
    cop_ack = 1'b0;
    chk("norm_wait_req", cop_req, 0);
    chk("norm_rsp_ack", cop_rsp_ack, 1);
    chk("norm_wb_early", wb_valid, 0);
    cop_rsp = 1'b1; cop_result = 3'd0; cop_wen = 1'b1; cop_waddr = 5'd5;
    cop_wdata = 32'hCAFEF00D;
    step();
    cop_rsp = 1'b0; cop_wdata = 32'h0; cop_waddr = 5'd0;
    chk("norm_wb_valid", wb_valid, 1);
    chk("norm_wb_code", wb_code, 0);
    chk("norm_wb_wen", wb_wen, 1);
    chk("norm_wb_waddr", wb_waddr, 5);
    chk("norm_wb_wdata", wb_wdata, 32'hCAFEF00D);
    chk("norm_wb_rdy", pl_ready, 0);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    chk("norm_back_idle", pl_ready, 1);
    chk("norm_wb_drop", wb_valid, 0);

    // Illegal opcode: wb at T+1, never contacts the coprocessor
    pl_valid = 1'b1; pl_insn = 32'h00000033; pl_rs1 = 32'h0;
    step();
    pl_valid = 1'b0;
    chk("ill_wb_valid", wb_valid, 1);
    chk("ill_code", wb_code, 3'b110);
    chk("ill_wen", wb_wen, 0);
    chk("ill_req", cop_req, 0);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    chk("ill_idle", pl_ready, 1);

    // Backpressure on cop_ack for 10 cycles, then ack+rsp same cycle
    pl_valid = 1'b1; pl_insn = 32'h0000002B; pl_rs1 = 32'h0000A5A5;
    step();
    pl_valid = 1'b0; pl_insn = 32'hFFFFFFFF; pl_rs1 = 32'h55555555;
    for (int i = 0; i < 10; i++) begin
      chk("bp_req", cop_req, 1);
      chk("bp_insn", cop_insn, 32'h0000002B);
      chk("bp_rs1", cop_rs1, 32'h0000A5A5);
      step();
    end
    chk("bp_req_end", cop_req, 1);
    cop_ack = 1'b1; cop_rsp = 1'b1; cop_result = 3'd3; cop_wen = 1'b1;
    cop_waddr = 5'd7; cop_wdata = 32'h11112222;
    step();
    cop_ack = 1'b0; cop_rsp = 1'b0; cop_result = 3'd0; cop_waddr = 5'd0; cop_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("bpw_valid", wb_valid, 1);
      chk("bpw_code", wb_code, 3'd3);
      chk("bpw_wen", wb_wen, 0);
      chk("bpw_waddr", wb_waddr, 7);
      chk("bpw_wdata", wb_wdata, 32'h11112222);
      step();
    end
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    chk("bp_idle", pl_ready, 1);

    // Timeout on the TIMEOUT=8 instance: 8 cycles in REQ, then code 111
    do_reset();
    pl_valid = 1'b1; pl_insn = 32'h0000005B; pl_rs1 = 32'h1;
    step();
    pl_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("to_req_held", t_cop_req, 1);
      chk("to_no_wb", t_wb_valid, 0);
      step();
    end
    chk("to_wb_valid", t_wb_valid, 1);
    chk("to_code", t_wb_code, 3'b111);
    chk("to_wen", t_wb_wen, 0);
    chk("to_req_drop", t_cop_req, 0);
    chk("to_main_still_req", cop_req, 1);
    do_reset();

    // Flush in REQ
    pl_valid = 1'b1; pl_insn = 32'h0000000B;
    step();
    pl_valid = 1'b0;
    pl_flush = 1'b1;
    step();
    pl_flush = 1'b0;
    chk("fr_req_drop", cop_req, 0);
    chk("fr_idle", pl_ready, 1);

    // Flush in WAIT, response later is discarded
    pl_valid = 1'b1; pl_insn = 32'h0000000B;
    step();
    pl_valid = 1'b0; cop_ack = 1'b1;
    step();
    cop_ack = 1'b0; pl_flush = 1'b1;
    step();
    pl_flush = 1'b0;
    chk("fw_still_wait", cop_rsp_ack, 1);
    chk("fw_no_wb0", wb_valid, 0);
    cop_rsp = 1'b1; cop_result = 3'd0; cop_wen = 1'b1; cop_waddr = 5'd9;
    step();
    cop_rsp = 1'b0;
    chk("fw_no_wb1", wb_valid, 0);
    chk("fw_idle", pl_ready, 1);
    step();
    chk("fw_no_wb2", wb_valid, 0);

    // Reset asserted in WAIT
    pl_valid = 1'b1; pl_insn = 32'h0000000B; pl_rs1 = 32'h0000BEEF;
    step();
    pl_valid = 1'b0; cop_ack = 1'b1;
    step();
    cop_ack = 1'b0;
    chk("rw_in_wait", cop_rsp_ack, 1);
    #1 g_reset = 1'b1;
    #1;
    chk("rw_rsp_ack", cop_rsp_ack, 0);
    chk("rw_pl_ready", pl_ready, 1);
    chk("rw_cop_insn", cop_insn, 0);
    chk("rw_cop_rs1", cop_rs1, 0);
    chk("rw_wb_valid", wb_valid, 0);
    step();
    g_reset = 1'b0;
    cop_rsp = 1'b1;
    step();
    cop_rsp = 1'b0;
    chk("rw_no_wb", wb_valid, 0);
    chk("rw_idle", pl_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
